// File: rtl/cop_gcd_lcm_ctrl_if.sv
// Port bundle between the EX-stage decoder/pipeline and the GCD/LCM coprocessor.
//
// Handshake: the decoder raises start (with cp_op, src_a, src_b) for a valid
// custom instruction in EX. The coprocessor accepts it only while idle and
// flush is low, and at once raises stall, which stays high until the result
// cycle. result_valid is a one-cycle pulse; stall is low in that cycle so the
// instruction retires with result. start seen while the unit is busy is ignored.
interface cop_gcd_lcm_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cp_op;
  logic             flush;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             overflow;

  modport master (
    output start, cp_op, flush, src_a, src_b,
    input  stall, busy, result, result_valid, overflow
  );

  modport slave (
    input  start, cp_op, flush, src_a, src_b,
    output stall, busy, result, result_valid, overflow
  );
endinterface

// File: rtl/cop_gcd_lcm_ctrl.sv
// GCD/LCM coprocessor: binary (Stein) GCD, then for LCM a restoring divide
// q = a0 / g followed by a shift-add multiply p = q * b0.
module cop_gcd_lcm_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  cop_gcd_lcm_ctrl_if.slave    bus,
  output logic [2:0]           dbg_state
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GCD  = 3'd1,
    S_DIV  = 3'd2,
    S_MUL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state;
  logic               op;
  logic [WIDTH-1:0]   a, b, a0, b0;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   g;
  logic [WIDTH-1:0]   dvd, quo, rem;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy_r, valid_r, ovf_r;
  logic [WIDTH-1:0]   result_r;

  logic               gcd_exit;
  logic [WIDTH-1:0]   gcd_base, g_val;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               rem_ge;
  logic [WIDTH-1:0]   quo_n;
  logic [2*WIDTH-1:0] acc_n;

  // Per-cycle datapath terms: GCD exit test, one divide step, one multiply step.
  always_comb begin
    gcd_exit = (a == '0) || (b == '0) || (a == b);
    gcd_base = (a == '0) ? b : a;
    g_val    = gcd_base << k;
    rem_sh   = {rem, dvd[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, g};
    rem_ge   = (rem_sh >= {1'b0, g});
    quo_n    = {quo[WIDTH-2:0], rem_ge};
    acc_n    = mplier[0] ? (acc + mcand) : acc;
  end

  // Controller and iterative datapath; reset wins over flush and start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op       <= 1'b0;
      a        <= '0;
      b        <= '0;
      a0       <= '0;
      b0       <= '0;
      k        <= '0;
      g        <= '0;
      dvd      <= '0;
      quo      <= '0;
      rem      <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      cnt      <= '0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      result_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          valid_r <= 1'b0;
          if (bus.start && !bus.flush) begin
            a      <= bus.src_a;
            b      <= bus.src_b;
            a0     <= bus.src_a;
            b0     <= bus.src_b;
            op     <= bus.cp_op;
            k      <= '0;
            busy_r <= 1'b1;
            state  <= S_GCD;
          end
        end

        S_GCD: begin
          if (bus.flush) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else if (gcd_exit) begin
            if (!op) begin
              result_r <= g_val;
              ovf_r    <= 1'b0;
              valid_r  <= 1'b1;
              state    <= S_DONE;
            end else if ((a0 == '0) || (b0 == '0)) begin
              // LCM with a zero operand is zero; skip the divide and multiply.
              result_r <= '0;
              ovf_r    <= 1'b0;
              valid_r  <= 1'b1;
              state    <= S_DONE;
            end else begin
              g     <= g_val;
              dvd   <= a0;
              rem   <= '0;
              quo   <= '0;
              cnt   <= '0;
              state <= S_DIV;
            end
          end else if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + KW'(1);
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a > b) begin
            a <= (a - b) >> 1;
          end else begin
            b <= (b - a) >> 1;
          end
        end

        S_DIV: begin
          if (bus.flush) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            // When the trial subtract fails the shifted remainder is below g,
            // so it still fits in WIDTH bits.
            rem <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            quo <= quo_n;
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              mcand  <= {{WIDTH{1'b0}}, b0};
              mplier <= quo_n;
              acc    <= '0;
              cnt    <= '0;
              state  <= S_MUL;
            end
          end
        end

        S_MUL: begin
          if (bus.flush) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            acc    <= acc_n;
            mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              result_r <= acc_n[WIDTH-1:0];
              ovf_r    <= |acc_n[2*WIDTH-1:WIDTH];
              valid_r  <= 1'b1;
              state    <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // The instruction has committed; flush and start have no effect here.
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall = ((state == S_IDLE) && bus.start && !bus.flush) ||
                     (state == S_GCD) || (state == S_DIV) || (state == S_MUL);
  assign bus.busy         = busy_r;
  assign bus.result       = result_r;
  assign bus.result_valid = valid_r;
  assign bus.overflow     = ovf_r;
  assign dbg_state        = state;

endmodule

// File: tb/tb_cop_gcd_lcm_ctrl.sv
// Bench for the GCD/LCM coprocessor: directed cases, flush/reset aborts and
// randomized operations checked against an arithmetic reference model.
module tb_cop_gcd_lcm_ctrl;

  localparam int W = 32;
  localparam int LAT_MAX = 4 * W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cop_gcd_lcm_ctrl_if #(.WIDTH(W)) bus();
  logic [2:0] dbg_state;

  cop_gcd_lcm_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] last_res = '0;
  bit           prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_gcd(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Returns {overflow, result}.
  function automatic logic [W:0] ref_op(input bit op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] g, p;
    g = ref_gcd(64'(x), 64'(y));
    if (!op) return {1'b0, g[W-1:0]};
    if (x == 0 || y == 0) return '0;
    p = (64'(x) / g) * 64'(y);
    return {|p[63:W], p[W-1:0]};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic [W:0] e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.result_valid) begin
        check("valid_one_cycle", 64'(prev_valid), 64'(0));
        check("busy_in_done", 64'(bus.busy), 64'(1));
        check("stall_in_done", 64'(bus.stall), 64'(0));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got result %0h with nothing pending", bus.result);
        end else begin
          e = exp_q.pop_front();
          check("result_ovf", 64'({bus.overflow, bus.result}), 64'(e));
          last_res = e[W-1:0];
        end
      end else begin
        check("result_hold", 64'(bus.result), 64'(last_res));
      end
      prev_valid = bus.result_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.result_valid), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_overflow", 64'(bus.overflow), 64'(0));
    check("rst_stall", 64'(bus.stall), 64'(0));
    last_res = '0;
    reset = 1'b0;
  endtask

  task automatic start_op(input bit op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.cp_op = op;
    bus.src_a = x;
    bus.src_b = y;
    bus.flush = 1'b0;
    #1;
    check("stall_on_start", 64'(bus.stall), 64'(1));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.cp_op = 1'($urandom);
    bus.src_a = $urandom;
    bus.src_b = $urandom;
  endtask

  // Waits for the result pulse; latency counts the accepting edge as 1.
  task automatic wait_done(input int exp_lat, input bit glitch);
    int c = 1;
    bit seen = 1'b0;
    while (!seen && c < LAT_MAX + 20) begin
      @(posedge clk);
      #1;
      c++;
      bus.start = 1'b0;
      if (bus.result_valid) begin
        seen = 1'b1;
      end else begin
        check("stall_busy_phase", 64'(bus.stall), 64'(1));
        check("busy_phase", 64'(bus.busy), 64'(1));
        if (glitch && c == 3) begin
          bus.start = 1'b1;
          bus.src_a = $urandom;
          bus.src_b = $urandom;
        end
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no result_valid after %0d cycles", c);
    end else begin
      n_checks++;
      if (c > LAT_MAX) begin
        n_fail++;
        $display("FAIL latency_bound: got %0d cycles, limit %0d", c, LAT_MAX);
      end
      if (exp_lat > 0) check("latency_exact", 64'(c), 64'(exp_lat));
      if (glitch) begin
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("start_in_done_ignored", 64'(bus.busy), 64'(0));
      end
    end
  endtask

  task automatic run(input bit op, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W:0] exp, input int exp_lat, input bit glitch);
    exp_q.push_back(exp);
    start_op(op, x, y);
    wait_done(exp_lat, glitch);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] x, y;
    bit op;
    int mode, sh;

    bus.start = 1'b0;
    bus.cp_op = 1'b0;
    bus.flush = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    do_reset();

    // Pin the model to hand-computed values.
    check("model_gcd_12_18", 64'(ref_op(1'b0, 32'd12, 32'd18)), 64'(6));
    check("model_lcm_4_6", 64'(ref_op(1'b1, 32'd4, 32'd6)), 64'(12));
    check("model_lcm_0_35", 64'(ref_op(1'b1, 32'd0, 32'd35)), 64'(0));
    check("model_lcm_ovf", 64'(ref_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE)), 64'({1'b1, 32'h2}));

    // Directed cases with literal expectations.
    run(1'b0, 32'd12, 32'd18, {1'b0, 32'd6}, 0, 1'b0);
    run(1'b1, 32'd4, 32'd6, {1'b0, 32'd12}, 0, 1'b0);
    run(1'b0, 32'd0, 32'd0, '0, 2, 1'b0);
    run(1'b0, 32'd0, 32'd35, {1'b0, 32'd35}, 2, 1'b0);
    run(1'b1, 32'd0, 32'd35, '0, 2, 1'b0);
    run(1'b1, 32'd35, 32'd0, '0, 2, 1'b0);
    run(1'b0, 32'd35, 32'd0, {1'b0, 32'd35}, 2, 1'b0);
    run(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, {1'b1, 32'h2}, 0, 1'b0);

    // Flush during the divide phase of LCM(9,6): aborted, nothing reported.
    start_op(1'b1, 32'd9, 32'd6);
    repeat (8) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'(0));
    check("flush_stall", 64'(bus.stall), 64'(0));
    repeat (2 * W + 4) @(posedge clk);
    run(1'b1, 32'd9, 32'd6, {1'b0, 32'd18}, 0, 1'b0);

    // Reset during the multiply phase, then back-to-back operations.
    start_op(1'b1, 32'd9, 32'd6);
    repeat (45) @(posedge clk);
    do_reset();
    run(1'b0, 32'd48, 32'd36, {1'b0, 32'd12}, 0, 1'b0);
    run(1'b1, 32'd7, 32'd5, {1'b0, 32'd35}, 0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      op   = 1'($urandom);
      mode = $urandom_range(0, 3);
      sh   = $urandom_range(0, 8);
      case (mode)
        0: begin x = $urandom_range(0, 100); y = $urandom_range(0, 100); end
        1: begin x = $urandom; y = $urandom; end
        2: begin x = 32'($urandom_range(1, 4000)) << sh; y = 32'($urandom_range(1, 4000)) << sh; end
        default: begin
          x = 32'($urandom_range(1, 300)) * 32'($urandom_range(1, 300));
          y = x * 32'($urandom_range(1, 50));
          if ($urandom_range(0, 1) == 1) begin x = y; y = x / 32'($urandom_range(1, 7)); end
        end
      endcase
      run(op, x, y, ref_op(op, x, y), 0, ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_results: got %0d left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #5000000;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
